signal_sync_filt: RTL and testbench

//   Multi-channel clock-domain synchroniser with per-channel glitch filter and edge detection.

---
 rtl/signal_sync_filt.sv | 101 ++++++++++
 tb/tb_signal_sync_filt.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/signal_sync_filt.sv
// Multi-channel async-input synchroniser with per-channel stability filter and edge strobes.
// Optional sticky edge flags with per-channel clear are enabled by defining SIGNAL_SYNC_STICKY_EN.
module signal_sync_filt #(
    parameter int unsigned CH      = 4,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned FILT    = 3,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [CH-1:0] i_signal,
`ifdef SIGNAL_SYNC_STICKY_EN
    input  logic [CH-1:0] i_clr,
    output logic [CH-1:0] o_pos_flag,
    output logic [CH-1:0] o_neg_flag,
`endif
    output logic [CH-1:0] o_signal,
    output logic [CH-1:0] o_valid,
    output logic [CH-1:0] o_edge,
    output logic [CH-1:0] o_posedge,
    output logic [CH-1:0] o_negedge
);

    localparam int unsigned   CW      = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("signal_sync_filt: STAGES must be >= 2");
    end
    if (FILT < 1) begin : g_bad_filt
        $error("signal_sync_filt: FILT must be >= 1");
    end

    logic [CH-1:0] stage [STAGES];
    logic [CH-1:0] s;
    logic [CW-1:0] cnt [CH];
    logic [CH-1:0] accept;

    assign s = stage[STAGES-1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage[i] <= {CH{RST_VAL}};
            end
        end else begin
            stage[0] <= i_signal;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // A channel accepts its synced level once it has differed for FILT consecutive cycles.
    always_comb begin
        accept  = '0;
        o_valid = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            accept[c]  = (s[c] != o_signal[c]) && (cnt[c] == CNT_MAX);
            o_valid[c] = (cnt[c] == '0) && (s[c] == o_signal[c]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned c = 0; c < CH; c++) begin
                cnt[c] <= '0;
            end
            o_signal  <= {CH{RST_VAL}};
            o_posedge <= '0;
            o_negedge <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (s[c] == o_signal[c] || accept[c]) begin
                    cnt[c] <= '0;
                end else begin
                    cnt[c] <= cnt[c] + CW'(1);
                end
            end
            o_signal  <= (o_signal & ~accept) | (s & accept);
            o_posedge <= accept & s;
            o_negedge <= accept & ~s;
        end
    end

    assign o_edge = o_posedge | o_negedge;

`ifdef SIGNAL_SYNC_STICKY_EN
    // Flags rise together with the edge strobe; a set in the same cycle overrides the clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_pos_flag <= '0;
            o_neg_flag <= '0;
        end else begin
            o_pos_flag <= (o_pos_flag & ~i_clr) | (accept & s);
            o_neg_flag <= (o_neg_flag & ~i_clr) | (accept & ~s);
        end
    end
`endif

endmodule

// File: tb/tb_signal_sync_filt.sv
// Directed, table-driven bench for signal_sync_filt (CH=4, STAGES=2, FILT=3, RST_VAL=0).
module tb_signal_sync_filt;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] i_signal;
    logic [3:0] o_signal, o_valid, o_edge, o_posedge, o_negedge;
`ifdef SIGNAL_SYNC_STICKY_EN
    logic [3:0] i_clr;
    logic [3:0] o_pos_flag, o_neg_flag;
`endif

    int tests  = 0;
    int failed = 0;

    signal_sync_filt #(
        .CH     (4),
        .STAGES (2),
        .FILT   (3),
        .RST_VAL(1'b0)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .i_signal (i_signal),
`ifdef SIGNAL_SYNC_STICKY_EN
        .i_clr     (i_clr),
        .o_pos_flag(o_pos_flag),
        .o_neg_flag(o_neg_flag),
`endif
        .o_signal (o_signal),
        .o_valid  (o_valid),
        .o_edge   (o_edge),
        .o_posedge(o_posedge),
        .o_negedge(o_negedge)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] in;
        logic [3:0] sig;
        logic [3:0] valid;
        logic [3:0] pos;
        logic [3:0] neg;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] sig, input logic [3:0] valid,
                             input logic [3:0] pos, input logic [3:0] neg);
        check({tag, " o_signal"},  o_signal,  sig);
        check({tag, " o_valid"},   o_valid,   valid);
        check({tag, " o_posedge"}, o_posedge, pos);
        check({tag, " o_negedge"}, o_negedge, neg);
        check({tag, " o_edge"},    o_edge,    pos | neg);
    endtask

    initial begin
        // ch0/ch2 rise and are accepted 4 edges later, ch1 carries a 2-cycle glitch,
        // then ch2 falls while ch3 rises in the same cycle.
        tbl[0]  = '{4'b0111, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0111, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0101, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0101, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0101, 4'b0101, 4'b1111, 4'b0101, 4'b0000};
        tbl[5]  = '{4'b0101, 4'b0101, 4'b1111, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1001, 4'b0101, 4'b1111, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1001, 4'b0101, 4'b0011, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b1001, 4'b0101, 4'b0011, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b1001, 4'b0101, 4'b0011, 4'b0000, 4'b0000};
        tbl[10] = '{4'b1001, 4'b1001, 4'b1111, 4'b1000, 4'b0100};
        tbl[11] = '{4'b1001, 4'b1001, 4'b1111, 4'b0000, 4'b0000};

        nrst     = 1'b0;
        i_signal = 4'h0;
`ifdef SIGNAL_SYNC_STICKY_EN
        i_clr    = 4'h0;
`endif
        #12;
        check_all("reset", 4'b0000, 4'b1111, 4'b0000, 4'b0000);
`ifdef SIGNAL_SYNC_STICKY_EN
        check("reset o_pos_flag", o_pos_flag, 4'b0000);
        check("reset o_neg_flag", o_neg_flag, 4'b0000);
`endif
        @(negedge clk);
        nrst = 1'b1;

        for (int v = 0; v < 12; v++) begin
            i_signal = tbl[v].in;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", v), tbl[v].sig, tbl[v].valid, tbl[v].pos, tbl[v].neg);
`ifdef SIGNAL_SYNC_STICKY_EN
            if (v == 4) check("vec4 o_pos_flag", o_pos_flag, 4'b0101);
            if (v == 10) begin
                check("vec10 o_pos_flag", o_pos_flag, 4'b1101);
                check("vec10 o_neg_flag", o_neg_flag, 4'b0100);
            end
`endif
            @(negedge clk);
        end

        // ch1 rises; reset lands while its filter count is at 2
        i_signal = 4'b1011;
        repeat (4) @(posedge clk);
        #1;
        check_all("midcount", 4'b1001, 4'b1101, 4'b0000, 4'b0000);
        #1;
        nrst = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
`ifdef SIGNAL_SYNC_STICKY_EN
        i_clr = 4'b0001;
`endif
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            case (e)
                0:       check_all("rel_e0", 4'b0000, 4'b1111, 4'b0000, 4'b0000);
                1, 2, 3: check_all($sformatf("rel_e%0d", e), 4'b0000, 4'b0100, 4'b0000, 4'b0000);
                4:       check_all("rel_e4", 4'b1011, 4'b1111, 4'b1011, 4'b0000);
                default: check_all("rel_e5", 4'b1011, 4'b1111, 4'b0000, 4'b0000);
            endcase
`ifdef SIGNAL_SYNC_STICKY_EN
            if (e == 4) check("rel_e4 o_pos_flag set beats clr", o_pos_flag, 4'b1011);
            if (e == 5) check("rel_e5 o_pos_flag cleared", o_pos_flag, 4'b1010);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
